// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (I)
// and load/store (D). One transaction outstanding at a time: IDLE picks a
// winner and latches its payload, REQ drives the memory request until
// accepted, RESP waits for the response and routes it to the owner.
// Optional feature macro MEM_ARB_RR_EN: round-robin arbitration on ties
// (default build: fixed priority, D wins every tie).
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_d_req,
  input  logic [ADDR_W-1:0]   i_d_addr,
  input  logic                i_d_wen,
  input  logic [DATA_W-1:0]   i_d_wdata,
  input  logic [DATA_W/8-1:0] i_d_mask,
  output logic                o_d_gnt,
  output logic                o_d_rvalid,
  output logic [DATA_W-1:0]   o_d_rdata,
  output logic                o_mem_req,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_wen,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_mask,
  input  logic                i_mem_ready,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_err
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic                owner_reg;     // 0 = I, 1 = D
  logic [ADDR_W-1:0]   addr_reg;
  logic                wen_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [MASK_W-1:0]   mask_reg;
  logic                err_reg;
  logic                load;          // accept a new transaction this cycle
  logic                pick_d;        // arbitration result: 1 = D wins

`ifdef MEM_ARB_RR_EN
  logic last_owner_reg;               // 0 = I, 1 = D; reset to D so I wins first tie

  // Round-robin winner: on a tie the port that did not own the last transaction wins
  always_comb begin
    if (i_if_req && i_d_req) begin
      pick_d = ~last_owner_reg;
    end else begin
      pick_d = i_d_req;
    end
  end

  // Remember who entered REQ most recently
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_owner_reg <= 1'b1;
    end else if (load) begin
      last_owner_reg <= pick_d;
    end
  end
`else
  // Fixed priority: any D request beats I
  always_comb begin
    pick_d = i_d_req;
  end
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic plus the combinational grant/response pulses
  always_comb begin
    state_next  = state_reg;
    load        = 1'b0;
    o_if_gnt    = 1'b0;
    o_d_gnt     = 1'b0;
    o_if_rvalid = 1'b0;
    o_d_rvalid  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_if_req || i_d_req) begin
          load       = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (i_mem_ready) begin
          o_if_gnt   = ~owner_reg;
          o_d_gnt    = owner_reg;
          state_next = RESP;
        end
      end
      RESP: begin
        if (i_mem_rvalid) begin
          o_if_rvalid = ~owner_reg;
          o_d_rvalid  = owner_reg;
          state_next  = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture owner and payload when a transaction is accepted; fetches are reads of a full word
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_reg <= 1'b0;
      addr_reg  <= '0;
      wen_reg   <= 1'b0;
      wdata_reg <= '0;
      mask_reg  <= '0;
    end else if (load) begin
      owner_reg <= pick_d;
      if (pick_d) begin
        addr_reg  <= i_d_addr;
        wen_reg   <= i_d_wen;
        wdata_reg <= i_d_wdata;
        mask_reg  <= i_d_mask;
      end else begin
        addr_reg  <= i_if_addr;
        wen_reg   <= 1'b0;
        wdata_reg <= '0;
        mask_reg  <= '1;
      end
    end
  end

  // Sticky error: a memory response arriving when no response is expected
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_reg <= 1'b0;
    end else if (i_mem_rvalid && (state_reg != RESP)) begin
      err_reg <= 1'b1;
    end
  end

  assign o_mem_req   = (state_reg == REQ);
  assign o_mem_addr  = addr_reg;
  assign o_mem_wen   = wen_reg;
  assign o_mem_wdata = wdata_reg;
  assign o_mem_mask  = mask_reg;
  assign o_if_rdata  = i_mem_rdata;
  assign o_d_rdata   = i_mem_rdata;
  assign o_err       = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: the bench acts as requesters and memory,
// and compares what it sees against a transaction-level model of the rules
// (who wins, what payload is presented, in which cycle gnt/rvalid appear).
// Honours MEM_ARB_RR_EN in its arbitration model.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        i_clk;
  logic        i_rst_n;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_d_req;
  logic [31:0] i_d_addr;
  logic        i_d_wen;
  logic [31:0] i_d_wdata;
  logic [3:0]  i_d_mask;
  logic        o_d_gnt;
  logic        o_d_rvalid;
  logic [31:0] o_d_rdata;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_ready;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_err;

  int checks = 0;
  int errors = 0;

  // Observations of one transaction, filled by do_mem_txn
  bit          obs_timeout;
  int          obs_req_cyc;
  logic [31:0] obs_addr;
  logic        obs_wen;
  logic [31:0] obs_wdata;
  logic [3:0]  obs_mask;
  bit          obs_stable;
  int          obs_if_gnt_n, obs_d_gnt_n, obs_gnt_cyc, obs_gnt_port;
  int          obs_if_rv_n, obs_d_rv_n, obs_rv_cyc, obs_rv_port;
  logic [31:0] obs_if_rdata, obs_d_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_if_req     (i_if_req),
    .i_if_addr    (i_if_addr),
    .o_if_gnt     (o_if_gnt),
    .o_if_rvalid  (o_if_rvalid),
    .o_if_rdata   (o_if_rdata),
    .i_d_req      (i_d_req),
    .i_d_addr     (i_d_addr),
    .i_d_wen      (i_d_wen),
    .i_d_wdata    (i_d_wdata),
    .i_d_mask     (i_d_mask),
    .o_d_gnt      (o_d_gnt),
    .o_d_rvalid   (o_d_rvalid),
    .o_d_rdata    (o_d_rdata),
    .o_mem_req    (o_mem_req),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wen    (o_mem_wen),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_mask   (o_mem_mask),
    .i_mem_ready  (i_mem_ready),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_err        (o_err)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Arbitration rule: lone requester wins; tie -> D (fixed) or the non-last owner (round-robin)
  function automatic int pick(input bit ip, input bit dp, input int last);
    if (ip && dp) return RR ? ((last == 1) ? 0 : 1) : 1;
    return dp ? 1 : 0;
  endfunction

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_if_req = 1'b0; i_d_req = 1'b0;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
  endtask

  task automatic sample_pulses(input int cyc);
    if (o_if_gnt)    begin obs_if_gnt_n++; obs_gnt_cyc = cyc; obs_gnt_port = 0; end
    if (o_d_gnt)     begin obs_d_gnt_n++;  obs_gnt_cyc = cyc; obs_gnt_port = 1; end
    if (o_if_rvalid) begin obs_if_rv_n++;  obs_rv_cyc = cyc;  obs_rv_port = 0; end
    if (o_d_rvalid)  begin obs_d_rv_n++;   obs_rv_cyc = cyc;  obs_rv_port = 1; end
  endtask

  // Plays the memory for one transaction. Entered at posedge+1 of an IDLE cycle
  // (cycle 0) with requests already driven; returns at posedge+1 of the next IDLE cycle.
  // The granted requester drops its req after the gnt edge.
  task automatic do_mem_txn(input int rw, input int rl, input logic [31:0] rd, input bit drop_early);
    int  cyc;
    int  waited;
    bit  found;
    obs_timeout = 0; obs_req_cyc = -1; obs_stable = 1;
    obs_if_gnt_n = 0; obs_d_gnt_n = 0; obs_gnt_cyc = -1; obs_gnt_port = -1;
    obs_if_rv_n = 0;  obs_d_rv_n = 0;  obs_rv_cyc = -1;  obs_rv_port = -1;
    obs_if_rdata = 'x; obs_d_rdata = 'x;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
    cyc = 0; found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge i_clk);
      sample_pulses(cyc);
      if (o_mem_req === 1'b1) found = 1;
      else begin @(posedge i_clk); #1; cyc++; end
    end
    if (!found) begin
      obs_timeout = 1;
      return;
    end
    obs_req_cyc = cyc;
    obs_addr = o_mem_addr; obs_wen = o_mem_wen; obs_wdata = o_mem_wdata; obs_mask = o_mem_mask;
    if (drop_early) begin
      i_if_req = 1'b0; i_d_req = 1'b0;
      i_if_addr = $urandom; i_d_addr = $urandom; i_d_wdata = $urandom;
    end
    waited = 0;
    while (waited < rw) begin
      @(posedge i_clk); #1; cyc++; waited++;
      @(negedge i_clk);
      sample_pulses(cyc);
      if (o_mem_req !== 1'b1 || o_mem_addr !== obs_addr || o_mem_wen !== obs_wen ||
          o_mem_wdata !== obs_wdata || o_mem_mask !== obs_mask) obs_stable = 0;
    end
    i_mem_ready = 1'b1;
    #1;
    sample_pulses(cyc);
    @(posedge i_clk); #1; cyc++;
    i_mem_ready = 1'b0;
    if (obs_gnt_port == 0) i_if_req = 1'b0;
    if (obs_gnt_port == 1) i_d_req = 1'b0;
    for (int k = 1; k < rl; k++) begin
      @(negedge i_clk);
      sample_pulses(cyc);
      @(posedge i_clk); #1; cyc++;
    end
    i_mem_rdata = rd; i_mem_rvalid = 1'b1;
    @(negedge i_clk);
    sample_pulses(cyc);
    obs_if_rdata = o_if_rdata; obs_d_rdata = o_d_rdata;
    @(posedge i_clk); #1;
    i_mem_rvalid = 1'b0; i_mem_rdata = $urandom;
  endtask

  task automatic test_reset();
    i_if_addr = 0; i_d_addr = 0; i_d_wen = 0; i_d_wdata = 0; i_d_mask = 0; i_mem_rdata = 0;
    i_rst_n = 1'b0;
    i_if_req = 1'b0; i_d_req = 1'b0; i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if ({o_mem_req, o_if_gnt, o_d_gnt, o_if_rvalid, o_d_rvalid, o_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req/ignt/dgnt/irv/drv/err=%b required 000000",
               {o_mem_req, o_if_gnt, o_d_gnt, o_if_rvalid, o_d_rvalid, o_err});
    end
    checks++;
    if (o_mem_addr !== 0 || o_mem_wen !== 0 || o_mem_wdata !== 0 || o_mem_mask !== 0) begin
      errors++;
      $display("FAIL reset_payload: addr=%h wen=%b wdata=%h mask=%h required all zero",
               o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: o_mem_req=%b required 0 with no request", o_mem_req);
    end
    @(posedge i_clk); #1;
    $display("txn reset: outputs checked in and after reset");
  endtask

  task automatic test_single_fetch();
    i_if_req = 1'b1; i_if_addr = 32'h100;
    do_mem_txn(0, 2, 32'hDEADBEEF, 0);
    checks++;
    if (obs_timeout || obs_req_cyc != 1) begin
      errors++; $display("FAIL fetch_req_cycle: mem_req at cycle %0d (timeout=%0d) required 1", obs_req_cyc, obs_timeout);
    end
    checks++;
    if (obs_addr !== 32'h100 || obs_wen !== 1'b0 || obs_wdata !== 0 || obs_mask !== 4'hF) begin
      errors++; $display("FAIL fetch_payload: addr=%h wen=%b wdata=%h mask=%h required 00000100/0/0/f",
                         obs_addr, obs_wen, obs_wdata, obs_mask);
    end
    checks++;
    if (obs_if_gnt_n != 1 || obs_d_gnt_n != 0 || obs_gnt_cyc != 1) begin
      errors++; $display("FAIL fetch_gnt: if_gnt=%0d d_gnt=%0d cycle=%0d required 1/0 at cycle 1",
                         obs_if_gnt_n, obs_d_gnt_n, obs_gnt_cyc);
    end
    checks++;
    if (obs_if_rv_n != 1 || obs_d_rv_n != 0 || obs_rv_cyc != 3 || obs_if_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL fetch_rvalid: if_rv=%0d d_rv=%0d cycle=%0d data=%h required 1/0 at cycle 3 data deadbeef",
                         obs_if_rv_n, obs_d_rv_n, obs_rv_cyc, obs_if_rdata);
    end
    $display("txn single_fetch: addr=%h gnt_cyc=%0d rv_cyc=%0d rdata=%h", obs_addr, obs_gnt_cyc, obs_rv_cyc, obs_if_rdata);
  endtask

  task automatic test_store_wait();
    i_d_req = 1'b1; i_d_addr = 32'h2000; i_d_wen = 1'b1; i_d_wdata = 32'h12345678; i_d_mask = 4'b0011;
    do_mem_txn(3, 1, 32'h0BADF00D, 0);
    checks++;
    if (obs_timeout || obs_req_cyc != 1 || obs_addr !== 32'h2000 || obs_wen !== 1'b1 ||
        obs_wdata !== 32'h12345678 || obs_mask !== 4'b0011) begin
      errors++; $display("FAIL store_payload: cyc=%0d addr=%h wen=%b wdata=%h mask=%h required 1/00002000/1/12345678/3",
                         obs_req_cyc, obs_addr, obs_wen, obs_wdata, obs_mask);
    end
    checks++;
    if (!obs_stable) begin
      errors++; $display("FAIL store_hold: request/payload changed during wait states, stable=%0d required 1", obs_stable);
    end
    checks++;
    if (obs_d_gnt_n != 1 || obs_if_gnt_n != 0 || obs_gnt_cyc != 4) begin
      errors++; $display("FAIL store_gnt: d_gnt=%0d if_gnt=%0d cycle=%0d required 1/0 at cycle 4",
                         obs_d_gnt_n, obs_if_gnt_n, obs_gnt_cyc);
    end
    checks++;
    if (obs_d_rv_n != 1 || obs_if_rv_n != 0 || obs_rv_cyc != 5) begin
      errors++; $display("FAIL store_ack: d_rv=%0d if_rv=%0d cycle=%0d required 1/0 at cycle 5",
                         obs_d_rv_n, obs_if_rv_n, obs_rv_cyc);
    end
    i_d_wen = 1'b0;
    $display("txn store_wait: addr=%h wdata=%h gnt_cyc=%0d ack_cyc=%0d", obs_addr, obs_wdata, obs_gnt_cyc, obs_rv_cyc);
  endtask

  task automatic test_simultaneous();
    int last = 1;
    int exp_port;
    do_reset();
    i_if_req = 1'b1; i_if_addr = 32'h0000_0400;
    i_d_req = 1'b1; i_d_addr = 32'h0000_8000; i_d_wen = 1'b0; i_d_wdata = 32'h55; i_d_mask = 4'hC;
    for (int t = 0; t < 3; t++) begin
      exp_port = pick(1'b1, 1'b1, last);
      do_mem_txn(0, 1, 32'h1000 + t, 0);
      checks++;
      if (obs_timeout || obs_gnt_port != exp_port || obs_if_gnt_n + obs_d_gnt_n != 1 || obs_rv_port != exp_port) begin
        errors++; $display("FAIL sim_owner t=%0d: gnt_port=%0d gnts=%0d rv_port=%0d required port %0d single gnt",
                           t, obs_gnt_port, obs_if_gnt_n + obs_d_gnt_n, obs_rv_port, exp_port);
      end
      checks++;
      if (obs_addr !== ((exp_port == 1) ? 32'h8000 : 32'h400)) begin
        errors++; $display("FAIL sim_addr t=%0d: addr=%h required %h", t, obs_addr, (exp_port == 1) ? 32'h8000 : 32'h400);
      end
      $display("txn simultaneous t=%0d: served port=%0d required %0d", t, obs_gnt_port, exp_port);
      last = exp_port;
      i_if_req = 1'b1; i_d_req = 1'b1;
    end
    i_if_req = 1'b0; i_d_req = 1'b0;
  endtask

  task automatic test_random();
    bit          ip = 0, dp = 0;
    logic [31:0] ia = 0, da = 0, dw = 0;
    logic        dwe = 0;
    logic [3:0]  dm = 0;
    int          last = 1;
    int          w, rw, rl;
    logic [31:0] rd, ea, ewd;
    logic        ewe;
    logic [3:0]  em;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin ip = 1; ia = $urandom; end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1; da = $urandom; dw = $urandom; dwe = 1'($urandom_range(0, 1)); dm = 4'($urandom);
      end
      if (!ip && !dp) begin ip = 1; ia = $urandom; end
      i_if_req = ip; i_if_addr = ia;
      i_d_req = dp; i_d_addr = da; i_d_wdata = dw; i_d_wen = dwe; i_d_mask = dm;
      w  = pick(ip, dp, last);
      rw = $urandom_range(0, 3);
      rl = $urandom_range(1, 3);
      rd = $urandom;
      if (w == 1) begin ea = da; ewe = dwe; ewd = dw; em = dm; end
      else        begin ea = ia; ewe = 1'b0; ewd = 32'h0; em = 4'hF; end
      do_mem_txn(rw, rl, rd, 0);
      checks++;
      if (obs_timeout || obs_gnt_port != w || obs_if_gnt_n + obs_d_gnt_n != 1 || obs_gnt_cyc != 1 + rw) begin
        errors++; $display("FAIL rand_gnt n=%0d: port=%0d gnts=%0d cyc=%0d timeout=%0d required port %0d once at cycle %0d",
                           n, obs_gnt_port, obs_if_gnt_n + obs_d_gnt_n, obs_gnt_cyc, obs_timeout, w, 1 + rw);
      end
      checks++;
      if (obs_addr !== ea || obs_wen !== ewe || obs_wdata !== ewd || obs_mask !== em || !obs_stable) begin
        errors++; $display("FAIL rand_payload n=%0d: addr=%h wen=%b wdata=%h mask=%h stable=%0d required %h/%b/%h/%h/1",
                           n, obs_addr, obs_wen, obs_wdata, obs_mask, obs_stable, ea, ewe, ewd, em);
      end
      checks++;
      if (obs_rv_port != w || obs_if_rv_n + obs_d_rv_n != 1 || obs_rv_cyc != 1 + rw + rl ||
          ((w == 1) ? obs_d_rdata : obs_if_rdata) !== rd) begin
        errors++; $display("FAIL rand_resp n=%0d: port=%0d rvs=%0d cyc=%0d required port %0d once at cycle %0d data %h",
                           n, obs_rv_port, obs_if_rv_n + obs_d_rv_n, obs_rv_cyc, w, 1 + rw + rl, rd);
      end
      $display("txn random n=%0d: pend I=%0d D=%0d served=%0d addr=%h wait=%0d lat=%0d", n, ip, dp, obs_gnt_port, obs_addr, rw, rl);
      if (w == 1) dp = 0; else ip = 0;
      last = w;
    end
    i_if_req = 1'b0; i_d_req = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_err !== 1'b0) begin
      errors++; $display("FAIL rand_err: o_err=%b required 0 after well-formed traffic", o_err);
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_spurious();
    i_mem_rdata = 32'hCAFE0001; i_mem_rvalid = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_if_rvalid !== 1'b0 || o_d_rvalid !== 1'b0) begin
      errors++; $display("FAIL spur_route: if_rv=%b d_rv=%b required 0/0", o_if_rvalid, o_d_rvalid);
    end
    @(posedge i_clk); #1;
    i_mem_rvalid = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if (o_err !== 1'b1 || o_mem_req !== 1'b0) begin
      errors++; $display("FAIL spur_err: o_err=%b mem_req=%b required 1/0", o_err, o_mem_req);
    end
    @(posedge i_clk); #1;
    i_if_req = 1'b1; i_if_addr = 32'h0000_0200;
    do_mem_txn(1, 1, 32'h600DD00D, 0);
    checks++;
    if (obs_timeout || obs_if_gnt_n != 1 || obs_if_rv_n != 1 || obs_rv_cyc != 3 || obs_if_rdata !== 32'h600DD00D) begin
      errors++; $display("FAIL spur_after: gnt=%0d rv=%0d rv_cyc=%0d data=%h required 1/1 at cycle 3 data 600dd00d",
                         obs_if_gnt_n, obs_if_rv_n, obs_rv_cyc, obs_if_rdata);
    end
    @(negedge i_clk);
    checks++;
    if (o_err !== 1'b1) begin
      errors++; $display("FAIL spur_sticky: o_err=%b required 1", o_err);
    end
    @(posedge i_clk); #1;
    $display("txn spurious: err=%b follow-up fetch rv_cyc=%0d", o_err, obs_rv_cyc);
  endtask

  task automatic test_reset_mid();
    i_if_req = 1'b1; i_if_addr = 32'h0000_0300;
    @(posedge i_clk); #1;          // REQ
    i_mem_ready = 1'b1;
    @(posedge i_clk); #1;          // RESP
    i_mem_ready = 1'b0; i_if_req = 1'b0;
    i_mem_rdata = 32'h77; i_mem_rvalid = 1'b1;
    #1;
    checks++;
    if (o_if_rvalid !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: o_if_rvalid=%b required 1 in response phase", o_if_rvalid);
    end
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_mem_req, o_if_gnt, o_d_gnt, o_if_rvalid, o_d_rvalid, o_err} !== 6'b0 || o_mem_addr !== 0 || o_mem_mask !== 0) begin
      errors++; $display("FAIL rstmid_async: ctrl=%b addr=%h mask=%h required 0/0/0",
                         {o_mem_req, o_if_gnt, o_d_gnt, o_if_rvalid, o_d_rvalid, o_err}, o_mem_addr, o_mem_mask);
    end
    i_mem_rvalid = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    i_if_req = 1'b1; i_if_addr = 32'h0000_0304;
    do_mem_txn(0, 2, 32'hABCD1234, 0);
    checks++;
    if (obs_timeout || obs_req_cyc != 1 || obs_gnt_cyc != 1 || obs_rv_cyc != 3 ||
        obs_if_rdata !== 32'hABCD1234 || obs_addr !== 32'h304) begin
      errors++; $display("FAIL rstmid_after: req_cyc=%0d gnt_cyc=%0d rv_cyc=%0d data=%h addr=%h required 1/1/3/abcd1234/00000304",
                         obs_req_cyc, obs_gnt_cyc, obs_rv_cyc, obs_if_rdata, obs_addr);
    end
    $display("txn reset_mid: fetch after reset rv_cyc=%0d", obs_rv_cyc);
  endtask

  task automatic test_withdrawal();
    i_if_req = 1'b1; i_if_addr = 32'h0000_0444;
    do_mem_txn(2, 1, 32'h13579BDF, 1);
    checks++;
    if (obs_timeout || obs_if_gnt_n != 1 || obs_d_gnt_n != 0 || obs_gnt_cyc != 3) begin
      errors++; $display("FAIL withdraw_gnt: if_gnt=%0d d_gnt=%0d cyc=%0d required 1/0 at cycle 3",
                         obs_if_gnt_n, obs_d_gnt_n, obs_gnt_cyc);
    end
    checks++;
    if (!obs_stable || obs_addr !== 32'h444) begin
      errors++; $display("FAIL withdraw_payload: addr=%h stable=%0d required 00000444/1", obs_addr, obs_stable);
    end
    checks++;
    if (obs_if_rv_n != 1 || obs_rv_cyc != 4 || obs_if_rdata !== 32'h13579BDF) begin
      errors++; $display("FAIL withdraw_rv: rv=%0d cyc=%0d data=%h required 1 at cycle 4 data 13579bdf",
                         obs_if_rv_n, obs_rv_cyc, obs_if_rdata);
    end
    $display("txn withdrawal: gnt_cyc=%0d rv_cyc=%0d", obs_gnt_cyc, obs_rv_cyc);
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_wait();
    test_simultaneous();
    test_random();
    test_spurious();
    test_reset_mid();
    test_withdrawal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between the instruction-fetch requester (port I) and the load/store requester (port D). It sits between the fetch stage / load-store unit and the unified memory model. It accepts one request at a time, captures its payload, and drives the memory port through a request/ready handshake. It then routes the memory response back to the requester that owns the transaction. Only one transaction is outstanding at any time.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; mask width is DATA_W/8
- i_clk  input  1  clock; all state changes on the rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_if_req  input  1  fetch request; held until o_if_gnt
- i_if_addr  input  ADDR_W  fetch address
- o_if_gnt  output  1  fetch request accepted by memory (1-cycle pulse)
- o_if_rvalid  output  1  fetch data valid (1-cycle pulse)
- o_if_rdata  output  DATA_W  fetch data
- i_d_req  input  1  load/store request; held until o_d_gnt
- i_d_addr  input  ADDR_W  data address
- i_d_wen  input  1  1 = store, 0 = load
- i_d_wdata  input  DATA_W  store data
- i_d_mask  input  DATA_W/8  byte-enable mask
- o_d_gnt  output  1  data request accepted (1-cycle pulse)
- o_d_rvalid  output  1  load data valid or store acknowledge (1-cycle pulse)
- o_d_rdata  output  DATA_W  load data
- o_mem_req  output  1  memory request
- o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask  output  ADDR_W/1/DATA_W/DATA_W/8  registered payload
- i_mem_ready  input  1  memory accepts request this cycle
- i_mem_rvalid  input  1  memory response valid
- i_mem_rdata  input  DATA_W  memory response data
- o_err  output  1  sticky protocol-error flag

## Operation
- FSM states: IDLE, REQ, RESP. Owner register: 0 = I, 1 = D.
- IDLE: if either request is asserted, pick a winner, latch the owner and the winner's payload, and go to REQ. Port I latches wen=0, wdata=0, and mask=all-ones. With no request, stay in IDLE.
- Arbitration, default: D has fixed priority over I.
- REQ: o_mem_req=1 with the latched payload.
  - When i_mem_ready is high, pulse the owner's gnt combinationally in the same cycle and go to RESP.
  - Otherwise, hold the request and payload.
- RESP: when i_mem_rvalid is high, pulse the owner's rvalid and go to IDLE.
  - Both o_*_rdata are driven combinationally from i_mem_rdata at all times.
  - Only the owner's rvalid qualifies the data.
  - Stores also receive o_d_rvalid as an acknowledge.
- Requesters must hold req stable until gnt. A req that drops while in REQ does not abort the transaction; the latched payload completes and gnt/rvalid still pulse.
- i_mem_rvalid in IDLE or REQ is ignored for routing and sets o_err. o_err is cleared only by reset.
- i_mem_ready outside REQ is ignored.

## Timing
- Reset state: state=IDLE, owner=0, all latched payload=0.
- Reset values of outputs: o_mem_req=0, o_if_gnt=0, o_d_gnt=0, o_if_rvalid=0, o_d_rvalid=0, o_err=0.
- Reset asserted mid-transaction returns immediately to IDLE and discards the transaction. The system must reset the memory together with the arbiter.
- Request at cycle 0 in IDLE gives o_mem_req=1 at cycle 1. gnt arrives at the first cycle ≥1 where i_mem_ready=1.
- rvalid arrives in the cycle i_mem_rvalid=1. The memory must return the response at least 1 cycle after acceptance.
- IDLE lasts at least 1 cycle between transactions. Back-to-back zero-wait-state transactions take 1 (IDLE) + 1 (REQ) + response latency cycles each.
- Requests asserted during REQ/RESP wait; they are arbitrated in the next IDLE cycle.

## Configuration
- MEM_ARB_RR_EN undefined: fixed priority, D wins every tie.
- MEM_ARB_RR_EN defined: round-robin using a last-owner register.
  - The last-owner register updates when a transaction enters REQ. Its reset value is D, so I wins the first tie.
  - On a tie, the port that was not the last owner wins.
  - A lone requester always wins.

## Test plan
- Single fetch: i_if_req=1, addr=0x100, ready=1 at cycle 1, rvalid at cycle 3 with rdata=0xDEADBEEF -> o_mem_addr=0x100, wen=0, mask=4'hF; o_if_gnt at cycle 1; o_if_rvalid at cycle 3 with 0xDEADBEEF; o_d_* quiet.
- Store with wait states: i_d_req, wen=1, addr=0x2000, wdata=0x12345678, mask=4'b0011; ready low for 3 cycles -> o_mem_req and payload held stable; o_d_gnt pulses once; o_d_rvalid pulses on ack.
- Simultaneous requests, both held for 3 transactions:
  - default: D, D, D served; I starved.
  - MEM_ARB_RR_EN: I, D, I served.
- Spurious response: i_mem_rvalid=1 while IDLE -> o_err=1 and stays 1; no rvalid pulse to either port; subsequent transactions complete normally.
- Reset mid-operation: i_rst_n low while in RESP -> all outputs 0 asynchronously; after release, a new fetch completes with the normal latency.
- Request withdrawal: i_if_req drops in REQ before ready -> the latched transaction still completes with o_if_gnt and o_if_rvalid.
